// File: rtl/sdram_arbit_pkg.sv
// Shared definitions for the SDRAM command arbiter: command codes, FSM states,
// request indices and default bus widths.
package sdram_arbit_pkg;

   localparam int ADDR_W_DEF = 12;
   localparam int BANK_W_DEF = 2;
   localparam int CMD_W_DEF  = 4;

   // {cs_n, ras_n, cas_n, we_n}
   localparam logic [3:0] CMD_NOP  = 4'b0111;
   localparam logic [3:0] CMD_PRE  = 4'b0010;
   localparam logic [3:0] CMD_AREF = 4'b0001;
   localparam logic [3:0] CMD_ACT  = 4'b0011;
   localparam logic [3:0] CMD_WR   = 4'b0100;
   localparam logic [3:0] CMD_RD   = 4'b0101;

   typedef enum logic [2:0] {
      ST_INIT  = 3'd0,
      ST_ARBIT = 3'd1,
      ST_AREF  = 3'd2,
      ST_WRITE = 3'd3,
      ST_READ  = 3'd4
   } state_e;

   localparam int REQ_REF = 0;
   localparam int REQ_WR  = 1;
   localparam int REQ_RD  = 2;

endpackage

// File: rtl/sdram_arbit_prio.sv
// Combinational request picker: refresh first, then write/read.
// SDRAM_ARBIT_RR_EN makes write/read alternate when both are pending.
module sdram_arbit_prio
   import sdram_arbit_pkg::*;
(
   input  logic [2:0] req_i,
`ifdef SDRAM_ARBIT_RR_EN
   input  logic       last_rd_i,
`endif
   output logic [2:0] grant_o
);

   always_comb begin
      grant_o = 3'b000;
      if (req_i[REQ_REF]) begin
         grant_o[REQ_REF] = 1'b1;
      end else if (req_i[REQ_WR] && req_i[REQ_RD]) begin
`ifdef SDRAM_ARBIT_RR_EN
         if (last_rd_i) grant_o[REQ_WR] = 1'b1;
         else           grant_o[REQ_RD] = 1'b1;
`else
         grant_o[REQ_WR] = 1'b1;
`endif
      end else if (req_i[REQ_WR]) begin
         grant_o[REQ_WR] = 1'b1;
      end else if (req_i[REQ_RD]) begin
         grant_o[REQ_RD] = 1'b1;
      end
   end

endmodule

// File: rtl/sdram_arbit.sv
// SDRAM command arbiter: holds INIT, then grants one engine at a time and muxes
// its command onto the pins. Optional macro: SDRAM_ARBIT_RR_EN (write/read round-robin).
//
// state    | meaning
// ---------+---------------------------------------------------
// ST_INIT  | init engine owns the pins until flag_init_end
// ST_ARBIT | idle, NOP on pins, picks the next engine
// ST_AREF  | auto-refresh engine owns the pins
// ST_WRITE | write engine owns the pins
// ST_READ  | read engine owns the pins
module sdram_arbit
   import sdram_arbit_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int BANK_W = BANK_W_DEF,
   parameter int CMD_W  = CMD_W_DEF
) (
   input  logic              sclk,
   input  logic              s_rst_n,
   input  logic              flag_init_end,
   input  logic [CMD_W-1:0]  init_cmd,
   input  logic [ADDR_W-1:0] init_addr,
   input  logic              ref_req,
   output logic              ref_en,
   input  logic              flag_ref_end,
   input  logic [CMD_W-1:0]  aref_cmd,
   input  logic [ADDR_W-1:0] aref_addr,
   input  logic              wr_req,
   output logic              wr_en,
   input  logic              flag_wr_end,
   input  logic [CMD_W-1:0]  wr_cmd,
   input  logic [BANK_W-1:0] wr_bank,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic              rd_req,
   output logic              rd_en,
   input  logic              flag_rd_end,
   input  logic [CMD_W-1:0]  rd_cmd,
   input  logic [BANK_W-1:0] rd_bank,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic              sdram_cke,
   output logic              sdram_cs_n,
   output logic              sdram_ras_n,
   output logic              sdram_cas_n,
   output logic              sdram_we_n,
   output logic [BANK_W-1:0] sdram_bank,
   output logic [ADDR_W-1:0] sdram_addr
);

   state_e            state_q, state_d;
   logic              ref_en_q, ref_en_d;
   logic              wr_en_q, wr_en_d;
   logic              rd_en_q, rd_en_d;
   logic              cke_q;
   logic [2:0]        req;
   logic [2:0]        grant;
   logic [CMD_W-1:0]  cmd_mux;
   logic [BANK_W-1:0] bank_mux;
   logic [ADDR_W-1:0] addr_mux;
`ifdef SDRAM_ARBIT_RR_EN
   logic              last_rd_q, last_rd_d;
`endif

   assign req[REQ_REF] = ref_req;
   assign req[REQ_WR]  = wr_req;
   assign req[REQ_RD]  = rd_req;

   sdram_arbit_prio u_prio (
      .req_i     (req),
`ifdef SDRAM_ARBIT_RR_EN
      .last_rd_i (last_rd_q),
`endif
      .grant_o   (grant)
   );

   always_comb begin
      state_d  = state_q;
      ref_en_d = 1'b0;
      wr_en_d  = 1'b0;
      rd_en_d  = 1'b0;
`ifdef SDRAM_ARBIT_RR_EN
      last_rd_d = last_rd_q;
`endif
      case (state_q)
         ST_INIT: begin
            if (flag_init_end) state_d = ST_ARBIT;
         end
         ST_ARBIT: begin
            // Grant is registered so it coincides with the first cycle in the new state
            if (grant[REQ_REF]) begin
               state_d  = ST_AREF;
               ref_en_d = 1'b1;
            end else if (grant[REQ_WR]) begin
               state_d = ST_WRITE;
               wr_en_d = 1'b1;
`ifdef SDRAM_ARBIT_RR_EN
               last_rd_d = 1'b0;
`endif
            end else if (grant[REQ_RD]) begin
               state_d = ST_READ;
               rd_en_d = 1'b1;
`ifdef SDRAM_ARBIT_RR_EN
               last_rd_d = 1'b1;
`endif
            end
         end
         ST_AREF: begin
            if (flag_ref_end) state_d = ST_ARBIT;
         end
         ST_WRITE: begin
            if (flag_wr_end) state_d = ST_ARBIT;
         end
         ST_READ: begin
            if (flag_rd_end) state_d = ST_ARBIT;
         end
         default: state_d = ST_INIT;
      endcase
   end

   always_ff @(posedge sclk or negedge s_rst_n) begin
      if (!s_rst_n) begin
         state_q  <= ST_INIT;
         ref_en_q <= 1'b0;
         wr_en_q  <= 1'b0;
         rd_en_q  <= 1'b0;
         cke_q    <= 1'b0;
`ifdef SDRAM_ARBIT_RR_EN
         last_rd_q <= 1'b1;
`endif
      end else begin
         state_q  <= state_d;
         ref_en_q <= ref_en_d;
         wr_en_q  <= wr_en_d;
         rd_en_q  <= rd_en_d;
         cke_q    <= 1'b1;
`ifdef SDRAM_ARBIT_RR_EN
         last_rd_q <= last_rd_d;
`endif
      end
   end

   always_comb begin
      cmd_mux  = CMD_W'(CMD_NOP);
      bank_mux = '0;
      addr_mux = '0;
      case (state_q)
         ST_INIT: begin
            cmd_mux  = init_cmd;
            addr_mux = init_addr;
         end
         ST_AREF: begin
            cmd_mux  = aref_cmd;
            addr_mux = aref_addr;
         end
         ST_WRITE: begin
            cmd_mux  = wr_cmd;
            bank_mux = wr_bank;
            addr_mux = wr_addr;
         end
         ST_READ: begin
            cmd_mux  = rd_cmd;
            bank_mux = rd_bank;
            addr_mux = rd_addr;
         end
         default: ;
      endcase
   end

   assign ref_en      = ref_en_q;
   assign wr_en       = wr_en_q;
   assign rd_en       = rd_en_q;
   assign sdram_cke   = cke_q;
   assign sdram_cs_n  = cmd_mux[3];
   assign sdram_ras_n = cmd_mux[2];
   assign sdram_cas_n = cmd_mux[1];
   assign sdram_we_n  = cmd_mux[0];
   assign sdram_bank  = bank_mux;
   assign sdram_addr  = addr_mux;

endmodule

// File: tb/tb_sdram_arbit.sv
// Self-checking bench for sdram_arbit: directed vector table, corner sequences and
// randomized traffic against a behavioural owner/grant model.
module tb_sdram_arbit;
   import sdram_arbit_pkg::*;

   localparam int O_INIT = 0;
   localparam int O_ARB  = 1;
   localparam int O_REF  = 2;
   localparam int O_WR   = 3;
   localparam int O_RD   = 4;

   logic        sclk = 1'b0;
   logic        s_rst_n = 1'b1;
   logic        flag_init_end = 1'b0;
   logic [3:0]  init_cmd = CMD_PRE;
   logic [11:0] init_addr = 12'h400;
   logic        ref_req = 1'b0, flag_ref_end = 1'b0;
   logic [3:0]  aref_cmd = CMD_AREF;
   logic [11:0] aref_addr = 12'h401;
   logic        wr_req = 1'b0, flag_wr_end = 1'b0;
   logic [3:0]  wr_cmd = CMD_WR;
   logic [1:0]  wr_bank = 2'd2;
   logic [11:0] wr_addr = 12'h123;
   logic        rd_req = 1'b0, flag_rd_end = 1'b0;
   logic [3:0]  rd_cmd = CMD_RD;
   logic [1:0]  rd_bank = 2'd3;
   logic [11:0] rd_addr = 12'h456;
   logic        ref_en, wr_en, rd_en;
   logic        sdram_cke, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n;
   logic [1:0]  sdram_bank;
   logic [11:0] sdram_addr;

   sdram_arbit dut (
      .sclk(sclk), .s_rst_n(s_rst_n), .flag_init_end(flag_init_end),
      .init_cmd(init_cmd), .init_addr(init_addr),
      .ref_req(ref_req), .ref_en(ref_en), .flag_ref_end(flag_ref_end),
      .aref_cmd(aref_cmd), .aref_addr(aref_addr),
      .wr_req(wr_req), .wr_en(wr_en), .flag_wr_end(flag_wr_end),
      .wr_cmd(wr_cmd), .wr_bank(wr_bank), .wr_addr(wr_addr),
      .rd_req(rd_req), .rd_en(rd_en), .flag_rd_end(flag_rd_end),
      .rd_cmd(rd_cmd), .rd_bank(rd_bank), .rd_addr(rd_addr),
      .sdram_cke(sdram_cke), .sdram_cs_n(sdram_cs_n), .sdram_ras_n(sdram_ras_n),
      .sdram_cas_n(sdram_cas_n), .sdram_we_n(sdram_we_n),
      .sdram_bank(sdram_bank), .sdram_addr(sdram_addr)
   );

   always #5 sclk = ~sclk;

   int n_chk = 0;
   int n_err = 0;

   // Behavioural model: who owns the bus, which grant is pulsing, W/R fairness memory
   int         m_own;
   logic [2:0] m_en;
   logic       m_cke;
   logic       m_wr_last;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [17:0] exp_pins(input int own);
      case (own)
         O_INIT:  return {init_cmd, 2'b00, init_addr};
         O_REF:   return {aref_cmd, 2'b00, aref_addr};
         O_WR:    return {wr_cmd, wr_bank, wr_addr};
         O_RD:    return {rd_cmd, rd_bank, rd_addr};
         default: return {CMD_NOP, 2'b00, 12'h000};
      endcase
   endfunction

   function automatic logic [17:0] act_pins();
      return {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n, sdram_bank, sdram_addr};
   endfunction

   task automatic model_reset();
      m_own = O_INIT;
      m_en = 3'b000;
      m_cke = 1'b0;
      m_wr_last = 1'b0;
   endtask

   task automatic model_edge();
      int pick;
      if (!s_rst_n) return;
      m_cke = 1'b1;
      m_en = 3'b000;
      pick = O_ARB;
      case (m_own)
         O_INIT: if (flag_init_end) m_own = O_ARB;
         O_ARB: begin
            if (ref_req)                pick = O_REF;
            else if (wr_req && rd_req) begin
`ifdef SDRAM_ARBIT_RR_EN
               pick = m_wr_last ? O_RD : O_WR;
`else
               pick = O_WR;
`endif
            end
            else if (wr_req)            pick = O_WR;
            else if (rd_req)            pick = O_RD;
            m_own = pick;
            if (pick == O_REF) m_en = 3'b100;
            if (pick == O_WR) begin m_en = 3'b010; m_wr_last = 1'b1; end
            if (pick == O_RD) begin m_en = 3'b001; m_wr_last = 1'b0; end
         end
         O_REF: if (flag_ref_end) m_own = O_ARB;
         O_WR:  if (flag_wr_end)  m_own = O_ARB;
         O_RD:  if (flag_rd_end)  m_own = O_ARB;
         default: m_own = O_INIT;
      endcase
   endtask

   task automatic model_check();
      chk("model_en", {29'd0, ref_en, wr_en, rd_en}, {29'd0, m_en});
      chk("model_cke", {31'd0, sdram_cke}, {31'd0, m_cke});
      chk("model_pins", {14'd0, act_pins()}, {14'd0, exp_pins(m_own)});
   endtask

   // Advance one clock; inputs were set after the previous edge
   task automatic step();
      @(posedge sclk);
      model_edge();
      #1;
      model_check();
   endtask

   task automatic clear_inputs();
      {ref_req, wr_req, rd_req, flag_ref_end, flag_wr_end, flag_rd_end} = '0;
   endtask

   task automatic async_reset_check();
      s_rst_n = 1'b0;
      model_reset();
      #1;
      chk("rst_en", {29'd0, ref_en, wr_en, rd_en}, 32'd0);
      chk("rst_cke", {31'd0, sdram_cke}, 32'd0);
      chk("rst_pins", {14'd0, act_pins()}, {14'd0, exp_pins(O_INIT)});
   endtask

   typedef struct {
      logic init_end, rq_ref, rq_wr, rq_rd, e_ref, e_wr, e_rd;
      int   exp_own;
      logic [2:0] exp_en;
   } vec_t;

   vec_t vt[17];
   logic [2:0] order[4];
   logic [2:0] exp_order[4];

   initial begin
      int got;
      vt[0]  = '{0,0,0,0,0,0,0, O_INIT, 3'b000};
      vt[1]  = '{1,0,0,0,0,0,0, O_ARB,  3'b000};
      vt[2]  = '{0,1,1,0,0,0,0, O_REF,  3'b100};
      vt[3]  = '{0,0,1,0,0,0,0, O_REF,  3'b000};
      vt[4]  = '{0,0,1,0,1,0,0, O_ARB,  3'b000};
      vt[5]  = '{0,0,1,0,0,0,0, O_WR,   3'b010};
      vt[6]  = '{0,0,1,1,0,0,0, O_WR,   3'b000};
      vt[7]  = '{0,0,0,1,0,1,0, O_ARB,  3'b000};
      vt[8]  = '{0,0,0,1,0,0,0, O_RD,   3'b001};
      vt[9]  = '{0,0,1,1,0,0,0, O_RD,   3'b000};
      vt[10] = '{0,0,1,1,0,0,1, O_ARB,  3'b000};
      vt[11] = '{0,0,1,1,0,0,0, O_WR,   3'b010};
      vt[12] = '{0,0,0,1,0,1,0, O_ARB,  3'b000};
      vt[13] = '{0,0,0,1,0,0,0, O_RD,   3'b001};
      vt[14] = '{0,0,0,0,0,0,0, O_RD,   3'b000};
      vt[15] = '{0,0,0,0,0,0,1, O_ARB,  3'b000};
      vt[16] = '{0,0,0,0,0,0,0, O_ARB,  3'b000};

      // Reset and hold init for 20 cycles
      model_reset();
      #2;
      init_cmd = CMD_ACT;
      async_reset_check();
      repeat (3) step();
      @(posedge sclk); #1;
      s_rst_n = 1'b1;
      init_cmd = CMD_PRE;
      step();
      chk("cke_after_release", {31'd0, sdram_cke}, 32'd1);
      repeat (20) step();
      chk("init_hold_pins", {14'd0, act_pins()}, {14'd0, exp_pins(O_INIT)});

      // Directed vector table
      for (int i = 0; i < 17; i++) begin
         flag_init_end = vt[i].init_end | (i > 1 ? 1'b0 : vt[i].init_end);
         {ref_req, wr_req, rd_req} = {vt[i].rq_ref, vt[i].rq_wr, vt[i].rq_rd};
         {flag_ref_end, flag_wr_end, flag_rd_end} = {vt[i].e_ref, vt[i].e_wr, vt[i].e_rd};
         step();
         chk($sformatf("vec%0d_en", i), {29'd0, ref_en, wr_en, rd_en}, {29'd0, vt[i].exp_en});
         chk($sformatf("vec%0d_pins", i), {14'd0, act_pins()}, {14'd0, exp_pins(vt[i].exp_own)});
      end
      clear_inputs();

      // Both write and read held: order of grants
`ifdef SDRAM_ARBIT_RR_EN
      exp_order = '{3'b010, 3'b001, 3'b010, 3'b001};
`else
      exp_order = '{3'b010, 3'b010, 3'b010, 3'b010};
`endif
      got = 0;
      wr_req = 1'b1;
      rd_req = 1'b1;
      for (int c = 0; c < 60 && got < 4; c++) begin
         step();
         flag_wr_end = 1'b0;
         flag_rd_end = 1'b0;
         if (wr_en || rd_en) begin
            order[got] = {1'b0, wr_en, rd_en};
            got++;
            flag_wr_end = wr_en;
            flag_rd_end = rd_en;
         end
      end
      chk("rr_grant_count", got, 4);
      for (int k = 0; k < 4; k++)
         if (k < got) chk($sformatf("rr_order%0d", k), {29'd0, order[k]}, {29'd0, exp_order[k]});
      rd_req = 1'b0;
      step();
      flag_wr_end = 1'b0;
      flag_rd_end = 1'b0;

      // Async reset in the middle of a write burst
      got = 0;
      for (int c = 0; c < 20 && got == 0; c++) begin
         step();
         if (wr_en) got = 1;
      end
      chk("mid_write_grant_seen", got, 1);
      wr_req = 1'b0;
      async_reset_check();
      step();
      @(posedge sclk); #1;
      s_rst_n = 1'b1;
      step();
      chk("cke_after_midrst", {31'd0, sdram_cke}, 32'd1);

      // Randomized traffic against the model
      for (int c = 0; c < 3000; c++) begin
         flag_init_end = ($urandom_range(0, 3) != 0);
         ref_req       = ($urandom_range(0, 7) == 0);
         wr_req        = ($urandom_range(0, 2) == 0);
         rd_req        = ($urandom_range(0, 2) == 0);
         flag_ref_end  = ($urandom_range(0, 3) == 0);
         flag_wr_end   = ($urandom_range(0, 3) == 0);
         flag_rd_end   = ($urandom_range(0, 3) == 0);
         init_cmd  = 4'($urandom);  init_addr = 12'($urandom);
         aref_cmd  = 4'($urandom);  aref_addr = 12'($urandom);
         wr_cmd    = 4'($urandom);  wr_addr   = 12'($urandom); wr_bank = 2'($urandom);
         rd_cmd    = 4'($urandom);  rd_addr   = 12'($urandom); rd_bank = 2'($urandom);
         if ($urandom_range(0, 499) == 0) begin
            async_reset_check();
            step();
            @(posedge sclk); #1;
            s_rst_n = 1'b1;
         end
         step();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
